sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter DATA_W, default 8: width of one input sample (the 8-bit sum stream).
REQ-002 Parameter ACC_W, default 10: width of the accumulated frame total.
REQ-003 Parameter CNT_W, default 4: width of frame-length field; frames of 1..2^CNT_W samples.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  enable; low freezes all state.
REQ-007 frame_len  input  CNT_W  samples per frame minus one.
REQ-008 in_valid  input  1  upstream sample valid.
REQ-009 in_data  input  DATA_W  upstream sample (unsigned).
REQ-010 in_ready  output  1  block accepts sample this cycle.
REQ-011 out_valid  output  1  frame total valid.
REQ-012 out_data  output  ACC_W  frame total (unsigned).
REQ-013 out_ready  input  1  downstream accepts total.
REQ-014 out_ovf  output  1  frame total overflowed ACC_W; qualified by out_valid.

Function
REQ-015 FSM SHALL have states ACCUM and HOLD only; transfers on a port occur when valid and ready are both high at a rising edge with ena high.
REQ-016 In ACCUM, in_ready SHALL equal ena; out_valid SHALL be 0.
REQ-017 frame_len SHALL be captured on the first accepted beat of each frame; changes mid-frame SHALL have no effect on that frame.
REQ-018 Each accepted beat SHALL add zero-extended in_data to the accumulator and increment the beat counter.
REQ-019 On the accepted beat where counter equals captured frame_len, FSM SHALL move to HOLD with out_data = accumulator + that beat, out_valid high the next cycle (latency 1 cycle from last beat).
REQ-020 In HOLD, in_ready SHALL be 0 and out_data/out_ovf/out_valid SHALL remain stable until out_ready is sampled high.
REQ-021 On output transfer, accumulator, counter and overflow flag SHALL clear and FSM SHALL return to ACCUM; in_ready rises the following cycle (no same-cycle pass-through).
REQ-022 frame_len = 0 SHALL yield one-sample frames: out_data = that sample.
REQ-023 ena low SHALL force in_ready low, hold all registers, and keep out_valid/out_data unchanged; out_ready is ignored while ena is low.
REQ-024 in_valid without in_ready, or out_ready without out_valid, SHALL have no effect.

Reset
REQ-025 rst_n low SHALL immediately force FSM to ACCUM, accumulator, counter, captured frame_len and overflow flag to 0; out_valid 0, out_data 0, out_ovf 0, in_ready 0 while in reset.
REQ-026 Reset mid-frame or in HOLD SHALL discard the partial frame/pending total; first beat after release starts a new frame.

Configuration
REQ-027 Macro SUM_ACC_SAT_EN defined: accumulator SHALL saturate at 2^ACC_W-1 and out_ovf SHALL go high (sticky for the frame) on any beat whose true sum exceeds it.
REQ-028 Macro SUM_ACC_SAT_EN undefined: accumulator SHALL wrap modulo 2^ACC_W and out_ovf SHALL be tied 0.

Structure
REQ-029 Package sum_acc_pkg SHALL hold the state enum (ACCUM, HOLD) and default DATA_W/ACC_W/CNT_W constants.
REQ-030 Sub-module sum_acc_add SHALL implement the ACC_W add with saturate/wrap selection and overflow output; all other logic lives in sum_accumulator.

Verification
REQ-031 Reset then frame_len=3, beats 10,20,30,40 back-to-back, out_ready=1 -> out_data=100, out_ovf=0, out_valid one cycle after 4th beat for one cycle.
REQ-032 frame_len=0, beat 0xFF, out_ready=0 for 5 cycles then 1 -> out_data=255 stable 6 cycles, in_ready=0 throughout HOLD.
REQ-033 SAT_EN defined, frame_len=4, five beats of 255 -> out_data=1023, out_ovf=1; undefined -> out_data=251, out_ovf=0.
REQ-034 frame_len=2, two beats of 5, assert rst_n low, release, frame_len=0, beat 7 -> out_data=7 (partial frame discarded).
REQ-035 frame_len=1, beat 3, ena low 4 cycles with in_valid high, ena high, beat 4 -> out_data=7; no beat accepted while ena low.
REQ-036 frame_len=1, change frame_len to 5 after first beat, beats 1,2 -> out_data=3 after second beat.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// ---------------------------------------------------------------------------
// sum_acc_pkg
//
// Purpose:
//   Shared definitions for the frame sum accumulator. Holds the two-state
//   FSM encoding and the default widths used by sum_accumulator and its
//   adder sub-module.
//
// Contents:
//   DEF_DATA_W  default width of one unsigned input sample
//   DEF_ACC_W   default width of the accumulated frame total
//   DEF_CNT_W   default width of the frame-length field
//   state_t     FSM state enum (ACCUM, HOLD)
//
// Configuration:
//   None here; see SUM_ACC_SAT_EN in sum_acc_add.sv.
// ---------------------------------------------------------------------------
package sum_acc_pkg;

  // Default widths: 8-bit samples, 10-bit totals, up to 16-sample frames.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 10;
  localparam int DEF_CNT_W  = 4;

  // ACCUM collects samples of the current frame; HOLD presents the frame
  // total downstream until it is taken.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage : sum_acc_pkg

// File: rtl/sum_acc_add.sv
// ---------------------------------------------------------------------------
// sum_acc_add
//
// Purpose:
//   Adds one zero-extended sample to the running ACC_W-bit frame total and
//   reports whether the true sum no longer fits in ACC_W bits. Whether the
//   result saturates or wraps is selected at build time.
//
// Ports:
//   i_acc   [ACC_W-1:0]   current running total
//   i_data  [DATA_W-1:0]  unsigned sample to add (DATA_W <= ACC_W)
//   o_sum   [ACC_W-1:0]   new running total (saturated or wrapped)
//   o_ovf                 true sum exceeded 2^ACC_W-1 (saturating build only)
//
// Configuration:
//   SUM_ACC_SAT_EN  defined   -> result clamps at 2^ACC_W-1, o_ovf reports
//                                the carry out of the ACC_W-bit add.
//                   undefined -> result wraps modulo 2^ACC_W, o_ovf is 0.
// ---------------------------------------------------------------------------
module sum_acc_add
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [DATA_W-1:0] i_data,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

`ifdef SUM_ACC_SAT_EN

  // One extra bit holds the carry so an overflow can be seen and clamped.
  logic [ACC_W:0] w_full;

  assign w_full = (ACC_W+1)'(i_acc) + (ACC_W+1)'(i_data);

  // Clamp to all-ones whenever the carry is set; the carry itself is the
  // overflow indication for this beat.
  assign o_sum = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
  assign o_ovf = w_full[ACC_W];

`else

  // Plain modulo-2^ACC_W add; the carry is simply dropped.
  assign o_sum = i_acc + ACC_W'(i_data);
  assign o_ovf = 1'b0;

`endif

endmodule : sum_acc_add

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Purpose:
//   Sums a stream of unsigned samples into frames of 1..2^CNT_W samples and
//   hands each frame total downstream over a valid/ready port. The frame
//   length (minus one) is captured on the first beat of each frame, so a
//   frame_len change mid-frame only affects the next frame. The total is
//   registered and appears one cycle after the last beat, then holds until
//   downstream takes it; no new samples are accepted while a total waits.
//
// Ports:
//   clk        sole clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   ena        enable; low freezes every register and blocks both ports
//   frame_len  [CNT_W-1:0]  samples per frame minus one
//   in_valid   upstream sample valid
//   in_data    [DATA_W-1:0] upstream sample (unsigned)
//   in_ready   sample accepted this cycle when in_valid is also high
//   out_valid  frame total valid
//   out_data   [ACC_W-1:0]  frame total (unsigned)
//   out_ready  downstream accepts the total
//   out_ovf    frame total overflowed ACC_W bits; qualified by out_valid
//
// Configuration:
//   SUM_ACC_SAT_EN  (consumed by sum_acc_add) selects saturating totals with
//                   a sticky overflow flag; undefined gives wrapping totals
//                   and out_ovf is always 0.
// ---------------------------------------------------------------------------
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [CNT_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              out_ovf
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_len;
  logic               r_ovf;
  logic [ACC_W-1:0]   r_outData;
  logic               r_outOvf;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic               w_inXfer;
  logic               w_outXfer;
  logic               w_firstBeat;
  logic               w_lastBeat;
  logic [CNT_W-1:0]   w_len;
  logic [ACC_W-1:0]   w_sum;
  logic               w_addOvf;

  // in_ready is gated by rst_n so it reads 0 for the whole time reset is
  // held, even though the state register already shows ACCUM.
  assign in_ready  = rst_n & ena & (r_state == ACCUM);
  assign w_inXfer  = in_ready & in_valid;
  assign w_outXfer = ena & (r_state == HOLD) & out_ready;

  // A counter of zero marks the first beat of a frame. On that beat the
  // live frame_len decides the length; afterwards the captured copy does.
  assign w_firstBeat = (r_cnt == '0);
  assign w_len       = w_firstBeat ? frame_len : r_len;
  assign w_lastBeat  = (r_cnt == w_len);

  // -------------------------------------------------------------------------
  // Adder: running total plus the current sample
  // -------------------------------------------------------------------------
  sum_acc_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .i_acc  (r_acc),
    .i_data (in_data),
    .o_sum  (w_sum),
    .o_ovf  (w_addOvf)
  );

  // -------------------------------------------------------------------------
  // Frame FSM with registered outputs
  //
  // ACCUM: every accepted beat adds into r_acc. The beat whose counter
  //        matches the frame length loads the output registers and moves
  //        to HOLD, so out_valid rises exactly one cycle after that beat.
  // HOLD:  the output registers are left untouched until out_ready is seen;
  //        then the frame state clears and ACCUM resumes on the next cycle,
  //        which keeps in_ready low during the cycle of the output transfer.
  // With ena low nothing below is evaluated, freezing every register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
      r_outData <= '0;
      r_outOvf  <= 1'b0;
    end else if (ena) begin
      case (r_state)
        ACCUM: begin
          if (w_inXfer) begin
            if (w_firstBeat) begin
              r_len <= frame_len;
            end
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_addOvf;
            if (w_lastBeat) begin
              r_outData <= w_sum;
              r_outOvf  <= r_ovf | w_addOvf;
              r_state   <= HOLD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (w_outXfer) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ACCUM;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs come straight from registers
  // -------------------------------------------------------------------------
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_outData;
  assign out_ovf   = r_outOvf;

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Purpose:
//   Self-checking bench for sum_accumulator. The main process drives
//   directed scenarios followed by randomized frames with random enable and
//   back-pressure, and a frame-level model pushes the expected total of each
//   completed frame into a queue. A separate monitor compares every cycle
//   in which out_valid is high against the head of that queue.
//
// Configuration:
//   Define SUM_ACC_SAT_EN for both the bench and the RTL to check the
//   saturating build; otherwise the wrapping build is expected.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 10;
  localparam int CNT_W   = 4;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic [CNT_W-1:0]  frame_len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;
  logic              out_ovf;

  typedef struct {
    int data;
    int ovf;
    int cycle;
  } exp_t;

  exp_t expQ[$];

  int checkCount = 0;
  int passCount  = 0;
  int cycleCount = 0;
  bit randomMode = 0;
  bit seenFront  = 0;

  // Frame-level reference model state
  int modelBeats = 0;
  int modelSum   = 0;
  int modelLen   = 0;

  sum_accumulator #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_ovf   (out_ovf)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to time the output latency
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual,
               expected, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    checkCount++;
    $display("[TB] FAIL %s: bound expired, got timeout, expected completion",
             name);
  endtask

  // Advance to the next falling edge; in random mode also re-roll the
  // enable and back-pressure there.
  task automatic tick();
    @(negedge clk);
    if (randomMode) begin
      ena       = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Frame rules: length is the frame_len seen on the first accepted beat,
  // the total is the plain sum of the samples, then clamped or wrapped.
  task automatic modelBeat(input int data, input int len, input int cyc);
    exp_t e;
    if (modelBeats == 0) modelLen = len;
    modelSum += data;
    modelBeats++;
    if (modelBeats == modelLen + 1) begin
`ifdef SUM_ACC_SAT_EN
      e.data = (modelSum > ACC_MAX) ? ACC_MAX : modelSum;
      e.ovf  = (modelSum > ACC_MAX) ? 1 : 0;
`else
      e.data = modelSum % (ACC_MAX + 1);
      e.ovf  = 0;
`endif
      e.cycle = cyc;
      expQ.push_back(e);
      modelBeats = 0;
      modelSum   = 0;
    end
  endtask

  task automatic modelReset();
    modelBeats = 0;
    modelSum   = 0;
    modelLen   = 0;
    expQ.delete();
  endtask

  // Offer one sample (called at a falling edge) and wait until it is
  // accepted; returns at the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic [DATA_W-1:0] data,
                               input logic [CNT_W-1:0] len);
    int  waited = 0;
    bit  accepted = 0;
    in_valid  = 1'b1;
    in_data   = data;
    frame_len = len;
    do begin
      #1;
      accepted = (in_ready === 1'b1);
      if (accepted) modelBeat(int'(in_data), int'(frame_len), cycleCount + 1);
      tick();
      waited++;
    end while (!accepted && waited < 300);
    in_valid = 1'b0;
    if (!accepted) failTimeout("beat_accept");
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || out_valid === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    if (expQ.size() != 0 || out_valid === 1'b1) failTimeout("drain");
  endtask

  // Monitor: whenever a total is presented, it must match the head of the
  // expected queue, arrive with the right latency, and block new samples.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) begin
        seenFront = 0;
      end else if (out_valid !== 1'b0) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out_valid", 32'(out_valid), 0);
        end else begin
          e = expQ[0];
          checkOutput("out_data", 32'(out_data), e.data);
          checkOutput("out_ovf", 32'(out_ovf), e.ovf);
          checkOutput("in_ready_in_hold", 32'(in_ready), 0);
          if (!seenFront) begin
            checkOutput("out_latency", cycleCount, e.cycle);
            seenFront = 1;
          end
          if (out_ready === 1'b1 && ena === 1'b1) begin
            void'(expQ.pop_front());
            seenFront = 0;
          end
        end
      end
    end
  end

  // Main stimulus: directed scenarios, then randomized frames
  initial begin
    int len;
    int beats;
    rst_n     = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    frame_len = '0;
    out_ready = 1'b0;

    // Reset values while reset is held with the block enabled
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 0);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_out_data", 32'(out_data), 0);
    checkOutput("reset_out_ovf", 32'(out_ovf), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    checkOutput("idle_in_ready", 32'(in_ready), 1);
    tick();

    // Four back-to-back beats, downstream always ready: 10+20+30+40
    $display("[TB] basic four-beat frame");
    out_ready = 1'b1;
    applyStimulus(8'd10, 4'd3);
    applyStimulus(8'd20, 4'd3);
    applyStimulus(8'd30, 4'd3);
    applyStimulus(8'd40, 4'd3);
    waitIdle(50);

    // Single-sample frame held under back-pressure for several cycles
    $display("[TB] single-sample frame with back-pressure");
    out_ready = 1'b0;
    applyStimulus(8'hFF, 4'd0);
    repeat (5) tick();
    out_ready = 1'b1;
    waitIdle(50);

    // Five full-scale beats overflow the 10-bit total
    $display("[TB] overflow frame");
    for (int i = 0; i < 5; i++) applyStimulus(8'd255, 4'd4);
    waitIdle(50);

    // Reset in the middle of a frame discards the partial sum
    $display("[TB] reset mid-frame");
    applyStimulus(8'd5, 4'd2);
    applyStimulus(8'd5, 4'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", 32'(in_ready), 0);
    checkOutput("midreset_out_data", 32'(out_data), 0);
    modelReset();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(8'd7, 4'd0);
    waitIdle(50);

    // Reset while a total is waiting drops that total
    $display("[TB] reset while holding a total");
    out_ready = 1'b0;
    applyStimulus(8'd9, 4'd0);
    tick();
    rst_n = 1'b0;
    modelReset();
    tick();
    #1;
    checkOutput("holdreset_out_valid", 32'(out_valid), 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();

    // Enable low blocks acceptance even with a valid sample offered
    $display("[TB] enable low mid-frame");
    applyStimulus(8'd3, 4'd1);
    ena      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("ena_low_in_ready", 32'(in_ready), 0);
      tick();
    end
    ena = 1'b1;
    applyStimulus(8'd4, 4'd1);
    waitIdle(50);

    // frame_len changed after the first beat must not stretch the frame
    $display("[TB] frame_len change mid-frame");
    applyStimulus(8'd1, 4'd1);
    applyStimulus(8'd2, 4'd5);
    waitIdle(50);

    // Randomized frames with random enable, back-pressure and frame_len churn
    $display("[TB] randomized frames");
    randomMode = 1;
    for (int f = 0; f < 30; f++) begin
      len   = $urandom_range(0, 15);
      beats = len + 1;
      for (int b = 0; b < beats; b++) begin
        applyStimulus(($urandom_range(0, 3) == 0) ? 8'd255
                                                  : 8'($urandom_range(0, 255)),
                      (b == 0) ? 4'(len) : 4'($urandom_range(0, 15)));
      end
    end
    waitIdle(400);
    randomMode = 0;
    ena        = 1'b1;
    out_ready  = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_sum_accumulator
